// File: rtl/wb_clint_if.sv
// Wishbone classic bus bundle between the data-side interconnect and the CLINT.
// Master drives the request, slave returns data and the termination.
interface wb_clint_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned SELE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  we;
   logic [SELE_WIDTH-1:0] sel;
   logic                  stb;
   logic                  cyc;
   logic                  ack;
   logic                  err;
   logic                  rty;

   modport master (output adr, wdata, we, sel, stb, cyc, input rdata, ack, err, rty);
   modport slave  (input adr, wdata, we, sel, stb, cyc, output rdata, ack, err, rty);
endinterface

// File: rtl/wb_clint.sv
// RISC-V core-local interruptor: msip, 64-bit mtime and mtimecmp behind a
// Wishbone classic slave with a registered single-cycle ack/err.
module wb_clint #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h0200_0000),
   parameter int unsigned            PRESCALE   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_clint_if.slave   wb,
   output logic        timer_irq,
   output logic        soft_irq
);
   localparam int unsigned SELE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned OFF_W      = 14;

   localparam logic [OFF_W-1:0] OFF_MSIP    = 14'h0000;
   localparam logic [OFF_W-1:0] OFF_CMP_LO  = 14'h1000;
   localparam logic [OFF_W-1:0] OFF_CMP_HI  = 14'h1001;
   localparam logic [OFF_W-1:0] OFF_TIME_LO = 14'h2FFE;
   localparam logic [OFF_W-1:0] OFF_TIME_HI = 14'h2FFF;

   logic [PW-1:0]         pcnt;
   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  msip;
   logic                  ack;
   logic                  err;
   logic [DATA_WIDTH-1:0] rdata;

   logic [OFF_W-1:0]      off;
   logic                  region_hit;
   logic                  decoded;
   logic                  hit;
   logic                  accept;
   logic                  wr;
   logic                  tick;
   logic [DATA_WIDTH-1:0] cur_word;
   logic [DATA_WIDTH-1:0] new_word;
   logic [63:0]           time_next;
   logic [63:0]           cmp_next;
   logic                  msip_next;
   logic                  unused_adr;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] cur,
      input logic [DATA_WIDTH-1:0] data,
      input logic [SELE_WIDTH-1:0] sel
   );
      logic [DATA_WIDTH-1:0] res;
      res = cur;
      for (int k = 0; k < int'(SELE_WIDTH); k++) begin
         if (sel[k]) res[8*k +: 8] = data[8*k +: 8];
      end
      return res;
   endfunction

   assign off        = wb.adr[15:2];
   assign unused_adr = ^wb.adr[1:0];
   assign region_hit = (wb.adr[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]);
   assign accept     = wb.cyc & wb.stb & ~ack & ~err;
   assign hit        = region_hit & decoded;
   assign wr         = accept & hit & wb.we;
   assign tick       = (pcnt == PW'(PRESCALE - 1));
   assign new_word   = merge_lanes(cur_word, wb.wdata, wb.sel);

   // Address decode; cur_word doubles as read data and the base for lane merging.
   always_comb begin
      decoded  = 1'b1;
      cur_word = '0;
      case (off)
         OFF_MSIP:    cur_word = {{(DATA_WIDTH-1){1'b0}}, msip};
         OFF_CMP_LO:  cur_word = mtimecmp[31:0];
         OFF_CMP_HI:  cur_word = mtimecmp[63:32];
         OFF_TIME_LO: cur_word = mtime[31:0];
         OFF_TIME_HI: cur_word = mtime[63:32];
         default:     decoded  = 1'b0;
      endcase
   end

   // A bus write to either mtime half replaces the increment for that cycle.
   always_comb begin
      time_next = tick ? (mtime + 64'd1) : mtime;
      cmp_next  = mtimecmp;
      msip_next = msip;
      if (wr) begin
         case (off)
            OFF_MSIP:    msip_next        = new_word[0];
            OFF_CMP_LO:  cmp_next[31:0]   = new_word;
            OFF_CMP_HI:  cmp_next[63:32]  = new_word;
            OFF_TIME_LO: time_next        = {mtime[63:32], new_word};
            OFF_TIME_HI: time_next        = {new_word, mtime[31:0]};
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt      <= '0;
         mtime     <= '0;
         mtimecmp  <= '1;
         msip      <= 1'b0;
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         timer_irq <= 1'b0;
      end else begin
         pcnt      <= tick ? '0 : (pcnt + PW'(1));
         mtime     <= time_next;
         mtimecmp  <= cmp_next;
         msip      <= msip_next;
         ack       <= accept & hit;
         err       <= accept & ~hit;
         rdata     <= (accept & hit & ~wb.we) ? cur_word : '0;
         timer_irq <= (mtime >= mtimecmp);
      end
   end

   assign soft_irq = msip;
   assign wb.ack   = ack;
   assign wb.err   = err;
   assign wb.rdata = rdata;
   assign wb.rty   = 1'b0;
endmodule

// File: tb/tb_wb_clint.sv
// Bench for wb_clint: two instances (PRESCALE 1 and 4) share one stimulus stream
// and are checked every cycle against a register-level model plus literal values.
module tb_wb_clint;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        cyc   = 1'b0;
   logic        stb   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] adr   = '0;
   logic [31:0] wdat  = '0;
   logic [3:0]  sel   = '0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   wb_clint_if bus0 ();
   wb_clint_if bus1 ();

   assign bus0.cyc = cyc;  assign bus0.stb = stb;  assign bus0.we = we;
   assign bus0.adr = adr;  assign bus0.wdata = wdat; assign bus0.sel = sel;
   assign bus1.cyc = cyc;  assign bus1.stb = stb;  assign bus1.we = we;
   assign bus1.adr = adr;  assign bus1.wdata = wdat; assign bus1.sel = sel;

   logic [1:0]  t_irq;
   logic [1:0]  s_irq;
   logic        d_ack [2];
   logic        d_err [2];
   logic        d_rty [2];
   logic [31:0] d_rd  [2];

   assign d_ack[0] = bus0.ack;   assign d_ack[1] = bus1.ack;
   assign d_err[0] = bus0.err;   assign d_err[1] = bus1.err;
   assign d_rty[0] = bus0.rty;   assign d_rty[1] = bus1.rty;
   assign d_rd[0]  = bus0.rdata; assign d_rd[1]  = bus1.rdata;

   wb_clint #(.PRESCALE(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .wb(bus0), .timer_irq(t_irq[0]), .soft_irq(s_irq[0]));
   wb_clint #(.PRESCALE(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .wb(bus1), .timer_irq(t_irq[1]), .soft_irq(s_irq[1]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned ps(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old & ~mask) | (nw & mask);
   endfunction

   // Register-level model: mtime counts edges since reset, bus writes override.
   int unsigned n_edges;
   logic [63:0] m_time [2];
   logic [63:0] m_cmp  [2];
   logic        m_msip [2];
   logic        m_tirq [2];
   logic [31:0] m_rd   [2];
   logic        m_ack, m_err;
   logic        acc, known;
   logic [15:0] moff;
   logic [63:0] nt;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         n_edges = 0; m_ack = 1'b0; m_err = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_time[i] = '0; m_cmp[i] = '1; m_msip[i] = 1'b0; m_tirq[i] = 1'b0; m_rd[i] = '0;
         end
      end else begin
         n_edges++;
         acc   = cyc && stb && !m_ack && !m_err;
         moff  = {adr[15:2], 2'b00};
         known = (adr[31:16] == 16'h0200) &&
                 (moff == 16'h0000 || moff == 16'h4000 || moff == 16'h4004 ||
                  moff == 16'hBFF8 || moff == 16'hBFFC);
         for (int i = 0; i < 2; i++) begin
            m_tirq[i] = (m_time[i] >= m_cmp[i]);
            nt = ((n_edges % ps(i)) == 0) ? m_time[i] + 64'd1 : m_time[i];
            m_rd[i] = '0;
            if (acc && known && !we) begin
               case (moff)
                  16'h0000: m_rd[i] = {31'd0, m_msip[i]};
                  16'h4000: m_rd[i] = m_cmp[i][31:0];
                  16'h4004: m_rd[i] = m_cmp[i][63:32];
                  16'hBFF8: m_rd[i] = m_time[i][31:0];
                  default:  m_rd[i] = m_time[i][63:32];
               endcase
            end
            if (acc && known && we) begin
               case (moff)
                  16'h0000: if (sel[0]) m_msip[i] = wdat[0];
                  16'h4000: m_cmp[i][31:0]  = lanes(m_cmp[i][31:0], wdat, sel);
                  16'h4004: m_cmp[i][63:32] = lanes(m_cmp[i][63:32], wdat, sel);
                  16'hBFF8: nt = {m_time[i][63:32], lanes(m_time[i][31:0], wdat, sel)};
                  default:  nt = {lanes(m_time[i][63:32], wdat, sel), m_time[i][31:0]};
               endcase
            end
            m_time[i] = nt;
         end
         m_ack = acc && known;
         m_err = acc && !known;
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("i%0d_ack", i),   64'(d_ack[i]),   64'(m_ack));
         check($sformatf("i%0d_err", i),   64'(d_err[i]),   64'(m_err));
         check($sformatf("i%0d_rty", i),   64'(d_rty[i]),   64'd0);
         check($sformatf("i%0d_rdata", i), 64'(d_rd[i]),    64'(m_rd[i]));
         check($sformatf("i%0d_tirq", i),  64'(t_irq[i]),   64'(m_tirq[i]));
         check($sformatf("i%0d_sirq", i),  64'(s_irq[i]),   64'(m_msip[i]));
      end
   end

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_err,
                       output logic [31:0] r0, output logic [31:0] r1);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      @(negedge clk);
      check("xfer_ack", 64'(bus0.ack), 64'(!exp_err));
      check("xfer_err", 64'(bus0.err), 64'(exp_err));
      r0 = bus0.rdata;
      r1 = bus1.rdata;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
   endtask

   logic [31:0] r0, r1;
   logic [31:0] exp_ps [5];
   int          k;

   initial begin
      exp_ps = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h12};
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(bus0.ack), 64'd0);
      check("rst_tirq", 64'(t_irq), 64'd0);
      check("rst_sirq", 64'(s_irq), 64'd0);
      rst_n = 1'b1;

      // free-running mtime after reset
      repeat (10) @(negedge clk);
      xfer(1'b0, 32'h0200_BFF8, 0, 4'hF, 1'b0, r0, r1);
      check("time_p1", 64'(r0), 64'd11);
      check("time_p4", 64'(r1), 64'd2);

      // timer compare rise and fall
      xfer(1'b1, 32'h0200_4004, 32'h0, 4'hF, 1'b0, r0, r1);
      xfer(1'b1, 32'h0200_4000, 32'h40, 4'hF, 1'b0, r0, r1);
      k = 0;
      while (!t_irq[0] && k < 200) begin @(negedge clk); k++; end
      check("irq_rise", 64'(t_irq[0]), 64'd1);
      xfer(1'b1, 32'h0200_4004, 32'h1, 4'hF, 1'b0, r0, r1);
      check("irq_lag", 64'(t_irq[0]), 64'd1);
      @(negedge clk);
      check("irq_fall", 64'(t_irq[0]), 64'd0);

      // 64-bit carry and full wrap
      xfer(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, 1'b0, r0, r1);
      xfer(1'b1, 32'h0200_BFFC, 32'h0, 4'hF, 1'b0, r0, r1);
      repeat (3) @(negedge clk);
      xfer(1'b0, 32'h0200_BFFC, 0, 4'hF, 1'b0, r0, r1);
      check("carry_hi", 64'(r0), 64'd1);
      xfer(1'b1, 32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, r0, r1);
      xfer(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, r0, r1);
      xfer(1'b0, 32'h0200_BFF8, 0, 4'hF, 1'b0, r0, r1);
      check("wrap_lo", 64'(r0), 64'd0);
      xfer(1'b0, 32'h0200_BFFC, 0, 4'hF, 1'b0, r0, r1);
      check("wrap_hi", 64'(r0), 64'd0);

      // msip lane behaviour
      xfer(1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'h2, 1'b0, r0, r1);
      check("msip_sel2", 64'(s_irq[0]), 64'd0);
      xfer(1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'h1, 1'b0, r0, r1);
      check("msip_set", 64'(s_irq[0]), 64'd1);
      xfer(1'b0, 32'h0200_0000, 0, 4'hF, 1'b0, r0, r1);
      check("msip_rd", 64'(r0), 64'd1);

      // error terminations leave state alone
      xfer(1'b0, 32'h0300_0000, 0, 4'hF, 1'b1, r0, r1);
      check("err_rd_region", 64'(r0), 64'd0);
      xfer(1'b1, 32'h0300_0000, 32'h0, 4'hF, 1'b1, r0, r1);
      xfer(1'b0, 32'h0200_1000, 0, 4'hF, 1'b1, r0, r1);
      check("err_rd_offset", 64'(r0), 64'd0);
      xfer(1'b1, 32'h0200_1000, 32'h0, 4'hF, 1'b1, r0, r1);
      xfer(1'b1, 32'h0300_4000, 32'h0, 4'hF, 1'b1, r0, r1);
      check("err_msip_kept", 64'(s_irq[0]), 64'd1);
      xfer(1'b0, 32'h0200_4000, 0, 4'hF, 1'b0, r0, r1);
      check("err_cmp_kept", 64'(r0), 64'h40);

      // sel=0 write and partial lanes, low address bits ignored
      xfer(1'b1, 32'h0200_4000, 32'h1234_5678, 4'h0, 1'b0, r0, r1);
      xfer(1'b0, 32'h0200_4000, 0, 4'hF, 1'b0, r0, r1);
      check("sel0_nochange", 64'(r0), 64'h40);
      xfer(1'b1, 32'h0200_4000, 32'hAABB_CCDD, 4'b0101, 1'b0, r0, r1);
      xfer(1'b0, 32'h0200_4003, 0, 4'h0, 1'b0, r0, r1);
      check("partial_lanes", 64'(r0), 64'h00BB_00DD);

      // write on a PRESCALE=4 increment edge suppresses that increment
      xfer(1'b1, 32'h0200_BFFC, 32'h0, 4'hF, 1'b0, r0, r1);
      xfer(1'b1, 32'h0200_BFF8, 32'h0, 4'hF, 1'b0, r0, r1);
      while (((n_edges + 2) % 4) != 0) @(negedge clk);
      xfer(1'b1, 32'h0200_BFF8, 32'h10, 4'h1, 1'b0, r0, r1);
      for (int j = 0; j < 5; j++) begin
         xfer(1'b0, 32'h0200_BFF8, 0, 4'hF, 1'b0, r0, r1);
         check($sformatf("ps4_read%0d", j), 64'(r1), 64'(exp_ps[j]));
      end

      // reset while ack is pending
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0200_0000; sel = 4'hF;
      @(posedge clk);
      #1;
      check("ack_pending", 64'(bus0.ack), 64'd1);
      rst_n = 1'b0;
      #1;
      check("ack_rst", 64'(bus0.ack), 64'd0);
      check("sirq_rst", 64'(s_irq), 64'd0);
      cyc = 1'b0; stb = 1'b0; adr = '0; sel = '0;
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b0, 32'h0200_4004, 0, 4'hF, 1'b0, r0, r1);
      check("rst_cmp_hi", 64'(r0), 64'hFFFF_FFFF);
      xfer(1'b0, 32'h0200_0000, 0, 4'hF, 1'b0, r0, r1);
      check("rst_msip", 64'(r0), 64'd0);
      xfer(1'b0, 32'h0200_BFFC, 0, 4'hF, 1'b0, r0, r1);
      check("rst_time_hi", 64'(r0), 64'd0);
      check("rst_tirq_after", 64'(t_irq), 64'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: bench did not complete, expected completion before t=200000");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
